// File: rtl/clk_gen_pkg.sv
// Shared types and helpers for the programmable clock divider.
package clk_gen_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  localparam int MIN_DIV = 2;

  // High time of a divide-by-N period, in master-clock cycles.
  function automatic logic [31:0] hi_time(input logic [31:0] n);
    return n >> 1;
  endfunction

endpackage

// File: rtl/clk_gen_divider.sv
// Programmable divide-by-N clock generator; ratio changes are deferred to period
// boundaries so clk_gen never glitches, and every output comes straight from a flop.
module clk_gen_divider
  import clk_gen_pkg::*;
#(
  parameter int DIV_WIDTH   = 8,
  parameter int DEFAULT_DIV = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic [DIV_WIDTH-1:0] div_ratio,
  input  logic                 div_load,
  output logic                 clk_gen,
  output logic                 gen_tick,
  output logic                 locked,
  output logic                 load_err
);

  localparam logic [DIV_WIDTH-1:0] DEF_RATIO = DIV_WIDTH'(DEFAULT_DIV);
  localparam logic [DIV_WIDTH-1:0] ONE       = DIV_WIDTH'(1);

  state_e               state_q, state_d;
  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
  logic [DIV_WIDTH-1:0] active_q, active_d;
  logic [DIV_WIDTH-1:0] pending_q, pending_d;
  logic                 pvld_q, pvld_d;
  logic                 clk_d, tick_d, lock_d, err_d;
  logic                 boundary, load_ok;
  logic [DIV_WIDTH-1:0] nxt_active;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    active_d   = active_q;
    pending_d  = pending_q;
    pvld_d     = pvld_q;
    clk_d      = clk_gen;
    tick_d     = 1'b0;
    lock_d     = locked;
    load_ok    = div_load && (div_ratio >= DIV_WIDTH'(MIN_DIV));
    err_d      = div_load && (div_ratio <  DIV_WIDTH'(MIN_DIV));
    boundary   = (state_q != IDLE) && (cnt_q == active_q - ONE);
    nxt_active = active_q;

    case (state_q)
      IDLE: begin
        cnt_d  = '0;
        clk_d  = 1'b0;
        lock_d = 1'b0;
        if (load_ok) active_d = div_ratio;
        if (enable) begin
          state_d = RUN;
          clk_d   = 1'b1;
          tick_d  = 1'b1;
        end
      end
      default: begin
        // The boundary sees the pending value from before this edge; a load on the
        // same cycle only refills the shadow register for the following boundary.
        if (boundary && pvld_q) begin
          nxt_active = pending_q;
          active_d   = pending_q;
          pvld_d     = 1'b0;
        end
        if (boundary) lock_d = !pvld_q;
        if (load_ok) begin
          pending_d = div_ratio;
          pvld_d    = 1'b1;
        end
        cnt_d  = boundary ? '0 : cnt_q + ONE;
        clk_d  = 32'(cnt_d) < hi_time(32'(nxt_active));
        tick_d = clk_d && !clk_gen;

        if (state_q == DRAIN) begin
          if (enable) begin
            state_d = RUN;
          end else if (boundary) begin
            state_d = IDLE;
            cnt_d   = '0;
            clk_d   = 1'b0;
            tick_d  = 1'b0;
            lock_d  = 1'b0;
          end
        end else if (!enable) begin
          state_d = DRAIN;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      active_q  <= DEF_RATIO;
      pending_q <= DEF_RATIO;
      pvld_q    <= 1'b0;
      clk_gen   <= 1'b0;
      gen_tick  <= 1'b0;
      locked    <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      active_q  <= active_d;
      pending_q <= pending_d;
      pvld_q    <= pvld_d;
      clk_gen   <= clk_d;
      gen_tick  <= tick_d;
      locked    <= lock_d;
      load_err  <= err_d;
    end
  end

endmodule

// File: tb/tb_clk_gen_divider.sv
// Directed bench for clk_gen_divider: hand-written per-cycle waveforms sampled on negedge.
module tb_clk_gen_divider;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic [7:0] div_ratio;
  logic       div_load;
  logic       clk_gen, gen_tick, locked, load_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  clk_gen_divider #(.DIV_WIDTH(8), .DEFAULT_DIV(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable   (enable),
    .div_ratio(div_ratio),
    .div_load (div_load),
    .clk_gen  (clk_gen),
    .gen_tick (gen_tick),
    .locked   (locked),
    .load_err (load_err)
  );

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // One character per cycle, left to right; div_load is dropped after each sample.
  task automatic seq(input string tag, input string c, input string t,
                     input string l, input string e);
    for (int i = 0; i < c.len(); i++) begin
      @(negedge clk);
      chk($sformatf("%s[%0d].clk_gen",  tag, i), clk_gen,  c[i] == 8'h31);
      chk($sformatf("%s[%0d].gen_tick", tag, i), gen_tick, t[i] == 8'h31);
      chk($sformatf("%s[%0d].locked",   tag, i), locked,   l[i] == 8'h31);
      chk($sformatf("%s[%0d].load_err", tag, i), load_err, e[i] == 8'h31);
      div_load = 1'b0;
    end
  endtask

  task automatic load(input logic [7:0] r);
    div_ratio = r;
    div_load  = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; div_ratio = '0; div_load = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst.clk_gen", clk_gen, 1'b0);
    chk("rst.gen_tick", gen_tick, 1'b0);
    chk("rst.locked", locked, 1'b0);
    chk("rst.load_err", load_err, 1'b0);
    rst_n = 1'b1; enable = 1'b1;

    // Default ratio 4 out of reset
    seq("t1", "11001100", "10001000", "00001111", "00000000");
    seq("t1b", "11", "10", "11", "00");

    // Mid-period switch to 3
    load(8'd3);
    seq("t2", "001001001", "001001001", "110001111", "000000000");
    load(8'd4);
    seq("t2b", "0011001", "0010001", "1100001", "0000000");

    // Illegal ratios are rejected
    load(8'd1);
    seq("t3a", "1", "0", "1", "1");
    load(8'd0);
    seq("t3b", "001100", "001000", "111111", "100000");

    // Disable on the second cycle: drain to the boundary, then idle
    seq("t4a", "1", "1", "1", "0");
    enable = 1'b0;
    seq("t4b", "10000", "00000", "11100", "00000");
    enable = 1'b1;
    seq("t4c", "11001", "10001", "00001", "00000");
    // Re-enable while draining: no gap
    enable = 1'b0;
    seq("t4d", "1", "0", "1", "0");
    enable = 1'b1;
    seq("t4e", "0011", "0010", "1111", "0000");

    // Maximum ratio 255: 127 high, 128 low
    load(8'd255);
    seq("t6a", "001", "001", "110", "000");
    for (int j = 1; j <= 510; j++) begin
      @(negedge clk);
      chk($sformatf("t6[%0d].clk_gen", j),  clk_gen,  (j % 255) < 127);
      chk($sformatf("t6[%0d].gen_tick", j), gen_tick, (j % 255) == 0);
      chk($sformatf("t6[%0d].locked", j),   locked,   j >= 255);
    end

    // Async reset while clk_gen is high, then restart at the default ratio
    chk("t5.pre.clk_gen", clk_gen, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5.async.clk_gen", clk_gen, 1'b0);
    chk("t5.async.gen_tick", gen_tick, 1'b0);
    chk("t5.async.locked", locked, 1'b0);
    @(negedge clk);
    chk("t5.hold.clk_gen", clk_gen, 1'b0);
    rst_n = 1'b1;
    seq("t5", "11001100", "10001000", "00001111", "00000000");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
